// File: rtl/framebuffer_scanout_if.sv
// Avalon-MM read master signals plus the outgoing pixel stream of the frame buffer scanout.
// "master" is the scanout side, "slave" is the memory/display side.
interface framebuffer_scanout_if #(
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [3:0]        master_byteenable;
  logic [31:0]       master_readdata;
  logic              master_readdatavalid;
  logic [31:0]       master_writedata;
  logic              master_waitrequest;
  logic [23:0]       pixel_color;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              pixel_sof;
  logic              pixel_eol;

  modport master (
    output master_address, master_read, master_write, master_byteenable, master_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest,
    output pixel_color, pixel_valid, pixel_sof, pixel_eol,
    input  pixel_ready
  );

  modport slave (
    input  master_address, master_read, master_write, master_byteenable, master_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input  pixel_color, pixel_valid, pixel_sof, pixel_eol,
    output pixel_ready
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Walks the frame buffer linearly with pipelined Avalon reads and streams the pixels
// out of a show-ahead FIFO with start-of-frame / end-of-line flags.
module framebuffer_scanout #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_buffer_base,
  framebuffer_scanout_if.master bus,
  output logic              frame_done,
  output logic              busy
);
  localparam int TOTAL = H_RES * V_RES;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int REQ_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [REQ_W-1:0]  req_reg;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [X_W-1:0]    x_reg;
  logic [Y_W-1:0]    y_reg;
  logic              frame_done_reg;
  logic [23:0]       fifo_mem [FIFO_DEPTH];

  logic [CNT_W:0] credit_used;
  logic           read_req;
  logic           accept;
  logic           push;
  logic           pop;
  logic           last_x;
  logic           last_y;
  logic           last_req;
  logic           unused_readdata;

  // Every word in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign read_req    = (state_reg == FETCH) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept      = read_req && !bus.master_waitrequest;
  // Returns with nothing outstanding are stale (e.g. issued before a reset) and dropped.
  assign push        = bus.master_readdatavalid && (outstanding_reg != '0);
  assign pop         = (count_reg != '0) && bus.pixel_ready;
  assign last_x      = (x_reg == X_W'(H_RES - 1));
  assign last_y      = (y_reg == Y_W'(V_RES - 1));
  assign last_req    = (req_reg == REQ_W'(TOTAL - 1));
  assign unused_readdata = ^bus.master_readdata[31:24];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      address_reg     <= '0;
      req_reg         <= '0;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      case ({accept, push})
        2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      if (pop) begin
        if (last_x) begin
          x_reg <= '0;
          y_reg <= last_y ? '0 : y_reg + Y_W'(1);
        end else begin
          x_reg <= x_reg + X_W'(1);
        end
      end

      case (state_reg)
        IDLE: begin
          if (enable) begin
            address_reg     <= frame_buffer_base;
            req_reg         <= '0;
            outstanding_reg <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            state_reg       <= FETCH;
          end
        end
        FETCH: begin
          if (accept) begin
            address_reg <= address_reg + ADDR_W'(4);
            req_reg     <= req_reg + REQ_W'(1);
            if (last_req) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last_x && last_y) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.master_readdata[23:0];
  end

  assign bus.master_address    = address_reg;
  assign bus.master_read       = read_req;
  assign bus.master_write      = 1'b0;
  assign bus.master_byteenable = 4'hF;
  assign bus.master_writedata  = 32'h0;
  assign bus.pixel_valid       = (count_reg != '0);
  assign bus.pixel_color       = bus.pixel_valid ? fifo_mem[rd_ptr_reg] : 24'h0;
  assign bus.pixel_sof         = bus.pixel_valid && (x_reg == '0) && (y_reg == '0);
  assign bus.pixel_eol         = bus.pixel_valid && last_x;
  assign frame_done            = frame_done_reg;
  assign busy                  = (state_reg != IDLE);
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench: a memory model answers reads, the stimulus pushes expected addresses
// and pixels per frame, and a separate monitor compares every popped pixel.
module tb_framebuffer_scanout;
  localparam int H_RES      = 4;
  localparam int V_RES      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 26;
  localparam int TOTAL      = H_RES * V_RES;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [ADDR_W-1:0] base;
  logic              frame_done;
  logic              busy;

  framebuffer_scanout_if #(.ADDR_W(ADDR_W)) bus ();

  framebuffer_scanout #(
    .H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .frame_buffer_base(base),
    .bus(bus),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr [$];
  logic [25:0]       exp_pix [$];   // {sof, eol, rgb}
  ret_t              ret_q [$];

  int latency   = 1;
  int stall_idx = -1;
  int stall_len = 0;
  int wait_pct  = 0;
  int ready_mode = 0;               // 0: always ready, 1: held low, 2: random

  int acc_count        = 0;
  int stall_cycles     = 0;
  int done_pulses      = 0;
  int accepts_in_frame = 0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: pixel p of the frame lives at base + 4p; sof at p=0, eol at end of each line.
  task automatic push_frame(input logic [ADDR_W-1:0] b);
    for (int p = 0; p < TOTAL; p++) begin
      logic [ADDR_W-1:0] a;
      logic [31:0]       w;
      a = b + ADDR_W'(4 * p);
      w = mem_word(a);
      exp_addr.push_back(a);
      exp_pix.push_back({(p == 0), ((p % H_RES) == H_RES - 1), w[23:0]});
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic pulse_enable();
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    #2;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      #2;
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse expected pulse within %0d cycles", budget);
    end
  endtask

  task automatic finish_test(input string tag, input int d0, input int a0, input int frames);
    repeat (4) tick();
    check({tag, "_done_pulses"}, 64'(done_pulses - d0), 64'(frames));
    check({tag, "_reads"}, 64'(acc_count - a0), 64'(frames * TOTAL));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
    check({tag, "_pix_left"}, 64'(exp_pix.size()), 64'd0);
    $display("test %s: frames=%0d reads=%0d", tag, done_pulses - d0, acc_count - a0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_read"}, 64'(bus.master_read), 64'd0);
    check({tag, "_addr"}, 64'(bus.master_address), 64'd0);
    check({tag, "_write"}, 64'(bus.master_write), 64'd0);
    check({tag, "_byteen"}, 64'(bus.master_byteenable), 64'hF);
    check({tag, "_wdata"}, 64'(bus.master_writedata), 64'd0);
    check({tag, "_pixel"}, 64'({bus.pixel_valid, bus.pixel_sof, bus.pixel_eol, bus.pixel_color}), 64'd0);
    check({tag, "_done_busy"}, 64'({frame_done, busy}), 64'd0);
  endtask

  // Memory slave + ready driver: drives at the falling edge for the next rising edge.
  initial begin : mem_model
    int                cyc;
    int                stall_done;
    int                acc_rst;
    int                pop_rst;
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic              wreq;
    ret_t              r;
    logic [ADDR_W-1:0] ea;
    cyc = 0; stall_done = 0; acc_rst = 0; pop_rst = 0;
    prev_stall = 1'b0; prev_addr = '0;
    bus.master_waitrequest   = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata      = 32'h0;
    bus.pixel_ready          = 1'b1;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        acc_rst = 0;
        pop_rst = 0;
        prev_stall = 1'b0;
      end else if (prev_stall) begin
        check("wait_hold_read", 64'(bus.master_read), 64'd1);
        check("wait_hold_addr", 64'(bus.master_address), 64'(prev_addr));
      end
      if (!busy) begin
        accepts_in_frame = 0;
        stall_done = 0;
      end
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata      = r.data;
      end else begin
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata      = $urandom;
      end
      wreq = 1'b0;
      if (bus.master_read) begin
        if (accepts_in_frame == stall_idx && stall_done < stall_len) begin
          wreq = 1'b1;
          stall_done++;
          stall_cycles++;
        end else if (wait_pct > 0 && $urandom_range(99) < wait_pct) begin
          wreq = 1'b1;
        end
      end
      bus.master_waitrequest = wreq;
      case (ready_mode)
        0:       bus.pixel_ready = 1'b1;
        1:       bus.pixel_ready = 1'b0;
        default: bus.pixel_ready = ($urandom_range(3) != 0);
      endcase
      prev_stall = bus.master_read && wreq;
      prev_addr  = bus.master_address;
      if (!reset && bus.master_read && !wreq) begin
        check("credit", 64'((acc_rst - pop_rst) < FIFO_DEPTH), 64'd1);
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got read at %0h expected no read", bus.master_address);
        end else begin
          ea = exp_addr.pop_front();
          check("read_addr", 64'(bus.master_address), 64'(ea));
        end
        ret_q.push_back('{cyc + latency, mem_word(bus.master_address)});
        accepts_in_frame++;
        acc_count++;
        acc_rst++;
      end
      if (!reset && bus.pixel_valid && bus.pixel_ready) pop_rst++;
    end
  end

  initial begin : pixel_monitor
    logic [25:0] got;
    logic [25:0] want;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        if (frame_done) done_pulses++;
        if (bus.pixel_valid && bus.pixel_ready) begin
          got = {bus.pixel_sof, bus.pixel_eol, bus.pixel_color};
          if (exp_pix.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected: got %h expected no pixel", got);
          end else begin
            want = exp_pix.pop_front();
            $display("pixel got %h expected %h", got, want);
            check("pixel", 64'(got), 64'(want));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int d0;
    int a0;
    int s0;
    reset  = 1'b1;
    enable = 1'b0;
    base   = '0;
    repeat (3) tick();
    check_zero_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Basic frame, zero-wait memory, single-cycle enable pulse.
    latency = 1;
    base = 26'h100000;
    d0 = done_pulses; a0 = acc_count;
    push_frame(base);
    pulse_enable();
    check("first_fetch", 64'({busy, bus.master_read, bus.master_address}), 64'({2'b11, 26'h100000}));
    wait_done(400);
    finish_test("basic", d0, a0, 1);

    // Waitrequest held for three cycles on the second read.
    stall_idx = 1; stall_len = 3;
    d0 = done_pulses; a0 = acc_count; s0 = stall_cycles;
    push_frame(base);
    pulse_enable();
    wait_done(400);
    finish_test("waitreq", d0, a0, 1);
    check("waitreq_stalls", 64'(stall_cycles - s0), 64'd3);
    stall_idx = -1; stall_len = 0;

    // Downstream stalled: credit allows exactly FIFO_DEPTH reads.
    ready_mode = 1;
    d0 = done_pulses; a0 = acc_count;
    push_frame(base);
    pulse_enable();
    repeat (20) tick();
    check("backpressure_reads", 64'(accepts_in_frame), 64'(FIFO_DEPTH));
    check("backpressure_read_low", 64'(bus.master_read), 64'd0);
    check("backpressure_valid", 64'(bus.pixel_valid), 64'd1);
    ready_mode = 0;
    wait_done(400);
    finish_test("backpressure", d0, a0, 1);

    // Long read latency.
    latency = 5;
    d0 = done_pulses; a0 = acc_count;
    push_frame(base);
    pulse_enable();
    wait_done(400);
    finish_test("latency5", d0, a0, 1);
    latency = 1;

    // Enable held, base changed mid-frame: new base applies to the next frame only.
    d0 = done_pulses; a0 = acc_count;
    push_frame(26'h100000);
    push_frame(26'h200000);
    @(negedge clock);
    enable = 1'b1;
    repeat (3) tick();
    base = 26'h200000;
    wait_done(400);
    check("bubble_idle", 64'(busy), 64'd0);
    tick();
    check("relaunch", 64'({busy, bus.master_read, bus.master_address}), 64'({2'b11, 26'h200000}));
    enable = 1'b0;
    wait_done(400);
    finish_test("b2b", d0, a0, 2);

    // Reset mid-FETCH with two reads outstanding; their data returns after release.
    latency = 8;
    base = 26'h100000;
    push_frame(base);
    pulse_enable();
    for (int i = 0; i < 50 && accepts_in_frame < 2; i++) tick();
    check("reset_setup_reads", 64'(accepts_in_frame), 64'd2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_addr.delete();
    exp_pix.delete();
    #1;
    check_zero_outputs("midreset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("post_reset_valid", 64'(bus.pixel_valid), 64'd0);
      check("post_reset_read", 64'(bus.master_read), 64'd0);
    end
    latency = 1;

    // Randomized frames: random base, latency, waitrequest and ready.
    for (int k = 0; k < 5; k++) begin
      base       = ADDR_W'($urandom_range(0, 32'h000F_FFFF) << 2);
      latency    = $urandom_range(1, 6);
      wait_pct   = 25;
      ready_mode = 2;
      d0 = done_pulses; a0 = acc_count;
      push_frame(base);
      pulse_enable();
      wait_done(2000);
      finish_test("random", d0, a0, 1);
    end
    ready_mode = 0;
    wait_pct   = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
